// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one synchronous dmem between processor and loader ports
module dmem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        p_req,
  input  logic        p_wren,
  input  logic [11:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic        p_gnt,
  output logic        p_rvalid,
  input  logic        d_req,
  input  logic        d_wren,
  input  logic [11:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] rdata,
  output logic [11:0] address_dmem,
  output logic [31:0] data,
  output logic        wren,
  input  logic [31:0] q_dmem,
  output logic [15:0] conflict_cnt
);
  typedef enum logic [1:0] {IDLE, P_ACC, D_ACC} state_t;
  state_t state, state_nxt;
  logic last, win_p, win_d;
  // last = 1 means the loader won most recently, so the processor wins the next tie
  always_comb begin
    win_p = p_req && (!d_req || last);
    win_d = d_req && (!p_req || !last);
    state_nxt = win_p ? P_ACC : win_d ? D_ACC : IDLE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last         <= 1'b1;
      address_dmem <= 12'd0;
      data         <= 32'd0;
      wren         <= 1'b0;
      p_rvalid     <= 1'b0;
      d_rvalid     <= 1'b0;
      conflict_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (win_p || win_d) begin
        last         <= win_d;
        address_dmem <= win_p ? p_addr : d_addr;
        data         <= win_p ? p_wdata : d_wdata;
      end
      wren     <= win_p ? p_wren : (win_d && d_wren);
      p_rvalid <= state == P_ACC && !wren;
      d_rvalid <= state == D_ACC && !wren;
      if (p_req && d_req && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
  assign p_gnt = state == P_ACC;
  assign d_gnt = state == D_ACC;
  assign rdata = q_dmem;
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL expose the following ports, one per line: name, direction, width, meaning. The clock and reset ports come first.
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- p_req  in  1  processor access request; held until granted.
- p_wren  in  1  processor write (1) or read (0).
- p_addr  in  12  processor word address.
- p_wdata  in  32  processor write data.
- p_gnt  out  1  processor request accepted this cycle.
- p_rvalid  out  1  rdata holds the processor read result.
- d_req  in  1  loader/debug port request; held until granted.
- d_wren  in  1  loader write (1) or read (0).
- d_addr  in  12  loader word address.
- d_wdata  in  32  loader write data.
- d_gnt  out  1  loader request accepted this cycle.
- d_rvalid  out  1  rdata holds the loader read result.
- rdata  out  32  shared read data, equal to q_dmem.
- address_dmem  out  12  dmem address.
- data  out  32  dmem write data.
- wren  out  1  dmem write enable.
- q_dmem  in  32  dmem read data, synchronous with 1-cycle latency.
- conflict_cnt  out  16  count of cycles in which both requesters asked.

REQ-002 SHALL use one clock domain (clock), with reset asynchronous and active-high. Both are fixed.

Function
REQ-003 SHALL sample p_req/d_req at each rising edge and issue at most one grant per edge.
REQ-004 SHALL register grants: p_gnt/d_gnt are high for exactly the one cycle following the granting edge. They are never high together.
REQ-005 SHALL drive address_dmem, data and wren from registers loaded at the granting edge with the winner's addr/wdata/wren.
REQ-006 SHALL hold wren at 0 in any cycle with no grant. Address and data hold their last values (no spurious writes).
REQ-007 SHALL raise the winner's rvalid for exactly one cycle when the granted access is a read. This is the cycle after gnt, with rdata = q_dmem.
REQ-008 SHALL assert no rvalid for writes.
REQ-009 SHALL support a new grant every cycle (fully pipelined). The rvalid of grant k coincides with gnt of grant k+1.
REQ-010 SHALL arbitrate with a 1-bit round-robin pointer `last`:
- only one requester active -> grant it;
- both active -> grant the side that was not granted last;
- `last` updates only on a grant.
REQ-011 SHALL treat a req still high in the cycle after its gnt as a new request. The requester must drop req in the gnt cycle to avoid a duplicate access.
REQ-012 SHALL bound the wait under continuous contention to 1 cycle: grants alternate P, D, P, D...
REQ-013 SHALL increment conflict_cnt on every edge where p_req and d_req are both high. It saturates at 0xFFFF and does not wrap.
REQ-014 SHALL be internally a 3-state FSM: IDLE (no grant), P_ACC (processor granted), D_ACC (loader granted).
- Next state follows REQ-010 every edge.
- Either ACC state moves to IDLE when no requests are present.

Reset
REQ-015 SHALL on reset force the following, immediately and independent of clock:
- p_gnt = d_gnt = 0, p_rvalid = d_rvalid = 0;
- wren = 0, address_dmem = 0, data = 0;
- conflict_cnt = 0, state = IDLE;
- `last` = loader, so the processor wins the first contention.
REQ-016 SHALL discard any in-flight read when reset asserts mid-operation. No rvalid appears after reset is released.
REQ-017 SHALL evaluate requests starting at the first rising edge after reset deasserts.

Verification
REQ-018 Single read: p_req=1, p_wren=0, p_addr=0x005 for one edge, dmem[5]=0xDEADBEEF.
- Expect p_gnt in the next cycle with address_dmem=0x005, wren=0.
- Expect p_rvalid=1 and rdata=0xDEADBEEF one cycle later.
REQ-019 Contention: p_req and d_req held high for 4 edges after reset.
- Expect grants P, D, P, D.
- Expect conflict_cnt=4.
- Never both gnt high together.
REQ-020 Write then read: d writes 0x12345678 to 0x0A0, then p reads 0x0A0 back-to-back.
- Expect wren=1 for exactly one cycle.
- Expect p_rvalid with rdata=0x12345678.
REQ-021 Idle: no requests for 10 cycles.
- Expect wren=0 and gnt/rvalid=0 throughout.
- conflict_cnt unchanged.
REQ-022 Reset mid-read: assert reset in the gnt cycle of a p read.
- Expect all outputs at reset values immediately.
- No p_rvalid after release.
- First contention afterwards grants P.
REQ-023 Saturation: preload conflict_cnt to 0xFFFE via 0xFFFE contention cycles, then 3 more.
- Expect conflict_cnt = 0xFFFF, held.
